dac_seq: RTL and testbench

DAC_SEQ -- requirements
Module: dac_seq

---
 rtl/dac_seq.sv | 164 ++++++++++++++++
 tb/tb_dac_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dac_seq.sv
// Two-segment (up/down) DAC waveform sequencer: plays samples from two small
// memories at a programmable tick rate, single-pass or continuous.
module dac_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIV_W-1:0]             divider,
  input  logic                         en,
  input  logic                         continuous,
  input  logic [$clog2(DEPTH+1)-1:0]   up_len,
  input  logic [$clog2(DEPTH+1)-1:0]   down_len,
  input  logic [DATA_W-1:0]            idle,
  input  logic                         wr_en,
  input  logic                         wr_sel,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            out,
  output logic                         busy,
  output logic                         seg,
  output logic                         done,
  output logic [$clog2(DEPTH)-1:0]     idx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  logic [DATA_W-1:0] up_mem [DEPTH];
  logic [DATA_W-1:0] dn_mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]     ul_q, ul_d, dl_q, dl_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              seg_q, seg_d;

  logic [LW-1:0]     ul_c, dl_c, seg_len_c;
  logic              tick_c, last_c;

  // Sample memories: unreset, writable at any time
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) dn_mem[wr_addr] <= wr_data;
      else        up_mem[wr_addr] <= wr_data;
    end
  end

  assign ul_c      = (up_len   > LW'(DEPTH)) ? LW'(DEPTH) : up_len;
  assign dl_c      = (down_len > LW'(DEPTH)) ? LW'(DEPTH) : down_len;
  assign tick_c    = (state_q != S_IDLE) && (cnt_q == divider);
  assign seg_len_c = (state_q == S_DOWN) ? dl_q : ul_q;
  assign last_c    = (LW'(idx_q) == (seg_len_c - LW'(1)));

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ul_d    = ul_q;
    dl_d    = dl_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        out_d = idle;
        idx_d = '0;
        cnt_d = '0;
        if (en && ((ul_c != '0) || (dl_c != '0))) begin
          ul_d = ul_c;
          dl_d = dl_c;
          if (ul_c != '0) begin
            state_d = S_UP;
            out_d   = up_mem[AW'(0)];
          end else begin
            state_d = S_DOWN;
            out_d   = dn_mem[AW'(0)];
          end
        end
      end
      S_UP, S_DOWN: begin
        // en has priority over a coincident tick
        if (!en) begin
          state_d = S_IDLE;
          out_d   = idle;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (!tick_c) begin
          cnt_d = cnt_q + DIV_W'(1);
        end else begin
          cnt_d = '0;
          if (!last_c) begin
            idx_d = idx_q + AW'(1);
            out_d = (state_q == S_DOWN) ? dn_mem[idx_d] : up_mem[idx_d];
          end else if ((state_q == S_UP) && (dl_q != '0)) begin
            state_d = S_DOWN;
            idx_d   = '0;
            out_d   = dn_mem[AW'(0)];
          end else if (continuous) begin
            idx_d = '0;
            if (ul_q != '0) begin
              state_d = S_UP;
              out_d   = up_mem[AW'(0)];
            end else begin
              state_d = S_DOWN;
              out_d   = dn_mem[AW'(0)];
            end
          end else begin
            state_d = S_IDLE;
            out_d   = idle;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = idle;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    seg_d  = (state_d == S_DOWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ul_q    <= '0;
      dl_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      seg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ul_q    <= ul_d;
      dl_q    <= dl_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      seg_q   <= seg_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign seg  = seg_q;
  assign done = done_q;
  assign idx  = idx_q;

endmodule

// File: tb/tb_dac_seq.sv
// Self-checking bench for dac_seq: expected per-cycle outputs come from a
// queue built by expanding each run into samples held divider+1 cycles.
module tb_dac_seq;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int DIVW  = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DIVW-1:0] divider;
  logic            en, continuous;
  logic [LW-1:0]   up_len, down_len;
  logic [DW-1:0]   idle;
  logic            wr_en, wr_sel;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   out;
  logic            busy, seg, done;
  logic [AW-1:0]   idx;

  always #5 clk = ~clk;

  dac_seq #(.DATA_W(DW), .DEPTH(DEPTH), .DIV_W(DIVW)) dut (
    .clk(clk), .rst_n(rst_n), .divider(divider), .en(en),
    .continuous(continuous), .up_len(up_len), .down_len(down_len),
    .idle(idle), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .out(out), .busy(busy), .seg(seg), .done(done),
    .idx(idx)
  );

  typedef struct packed {
    logic [DW-1:0] o;
    logic          b;
    logic          s;
    logic          d;
    logic [AW-1:0] i;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] m_up [DEPTH];
  logic [DW-1:0] m_dn [DEPTH];
  int            checks = 0;
  int            failures = 0;
  int            last_start;
  int            cur_np;

  function automatic exp_t mk(logic [DW-1:0] o, logic b, logic s, logic d, int i);
    exp_t e;
    e.o = o; e.b = b; e.s = s; e.d = d; e.i = AW'(i);
    return e;
  endfunction

  function automatic int clamp(int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_entry(int k, exp_t e);
    chk("out",  k, 32'(out),  32'(e.o));
    chk("busy", k, 32'(busy), 32'(e.b));
    chk("seg",  k, 32'(seg),  32'(e.s));
    chk("done", k, 32'(done), 32'(e.d));
    chk("idx",  k, 32'(idx),  32'(e.i));
  endtask

  task automatic wr(logic sel, int a, logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) m_dn[a] = d;
    else     m_up[a] = d;
  endtask

  // Expected waveform: np passes of up then down samples, each held dv+1 cycles
  task automatic build(int ul, int dl, int dv, int np);
    q.delete();
    last_start = (np - 1) * (ul + dl) * (dv + 1);
    if (ul + dl == 0) begin
      repeat (3) q.push_back(mk(idle, 1'b0, 1'b0, 1'b0, 0));
      return;
    end
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < ul; i++)
        repeat (dv + 1) q.push_back(mk(m_up[i], 1'b1, 1'b0, 1'b0, i));
      for (int i = 0; i < dl; i++)
        repeat (dv + 1) q.push_back(mk(m_dn[i], 1'b1, 1'b1, 1'b0, i));
    end
    q.push_back(mk(idle, 1'b0, 1'b0, 1'b1, 0));
  endtask

  task automatic start(int u, int d, int dv, int np);
    up_len = LW'(u); down_len = LW'(d); divider = DIVW'(dv);
    continuous = (np > 1); en = 1'b1; cur_np = np;
    build(clamp(u), clamp(d), dv, np);
  endtask

  task automatic play(int n, int wr_at, output int busy_cnt);
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      chk_entry(k, q[k]);
      if (busy) busy_cnt++;
      // Length inputs are ignored once running
      if (k == 0 && q[0].b) begin
        up_len   = LW'($urandom_range(0, DEPTH + 3));
        down_len = LW'($urandom_range(0, DEPTH + 3));
      end
      if (cur_np > 1 && k == last_start) continuous = 1'b0;
      if (k == wr_at) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = q[k].i;
        wr_data = ~m_up[q[k].i];
        m_up[q[k].i] = ~m_up[q[k].i];
      end
      if (k == q.size() - 1) en = 1'b0;
    end
    wr_en = 1'b0;
  endtask

  task automatic run(int u, int d, int dv, int np, int wr_at);
    int bc;
    start(u, d, dv, np);
    play(q.size(), wr_at, bc);
    chk("busy_cycles", 0, 32'(bc), 32'((clamp(u) + clamp(d)) * (dv + 1) * np));
  endtask

  initial begin
    int bc;
    rst_n = 1'b1; en = 1'b0; continuous = 1'b0; up_len = '0; down_len = '0;
    idle = 8'hA5; divider = '0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0;
    wr_data = '0;

    #2 rst_n = 1'b0;
    #2 chk_entry(-1, mk(8'h00, 1'b0, 1'b0, 1'b0, 0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk("idle_after_reset", -1, 32'(out), 32'h0A5);

    wr(1'b0, 0, 8'd1); wr(1'b0, 1, 8'd2); wr(1'b0, 2, 8'd3);
    wr(1'b1, 0, 8'd9); wr(1'b1, 1, 8'd8);
    run(3, 2, 0, 1, -1);
    run(3, 2, 3, 1, -1);

    wr(1'b1, 0, 8'd5); wr(1'b1, 1, 8'd6);
    run(0, 2, 0, 4, -1);

    // Abort during the second up sample, then restart from up[0]
    start(3, 2, 2, 1);
    play(4, -1, bc);
    en = 1'b0;
    @(negedge clk) chk_entry(100, mk(idle, 1'b0, 1'b0, 1'b0, 0));
    run(3, 2, 2, 1, -1);

    for (int i = 0; i < DEPTH; i++) wr(1'b0, i, DW'($urandom));
    run(DEPTH + 3, 1, 0, 1, -1);
    run(0, 0, 0, 1, -1);

    // Rewrite the sample being played; new value shows on the next run
    run(4, 1, 3, 1, 0);
    run(1, 0, 0, 1, -1);

    // Reset in the down segment
    start(3, 2, 1, 1);
    play(7, -1, bc);
    rst_n = 1'b0; en = 1'b0;
    #1 chk_entry(200, mk(8'h00, 1'b0, 1'b0, 1'b0, 0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk_entry(201, mk(idle, 1'b0, 1'b0, 1'b0, 0));

    repeat (8) begin
      for (int i = 0; i < DEPTH; i++) wr(1'b0, i, DW'($urandom));
      for (int i = 0; i < DEPTH; i++) wr(1'b1, i, DW'($urandom));
      idle = DW'($urandom);
      run(int'($urandom_range(0, DEPTH + 3)), int'($urandom_range(0, DEPTH + 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
